fft8_frame_loader: RTL

Upstream input stage for the 8-point FFT datapath. It takes a serial stream of real samples over a valid/ready handshake and assembles them into 8-sample frames. Each complete frame is presented in parallel on A0..A7, the eight real inputs of the combinational fft8 core, and held stable until the consumer accepts it. The block is double-buffered (one fill buffer, one output buffer), so the stream can run without gaps while the output frame is held.

---
 rtl/fft8_frame_loader.sv | 100 ++++++++++
 1 files changed

// File: rtl/fft8_frame_loader.sv
// fft8_frame_loader: double-buffered serial-to-parallel 8-sample frame loader feeding the fft8 core.
module fft8_frame_loader #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [DATA_W-1:0] A0,
    output logic [DATA_W-1:0] A1,
    output logic [DATA_W-1:0] A2,
    output logic [DATA_W-1:0] A3,
    output logic [DATA_W-1:0] A4,
    output logic [DATA_W-1:0] A5,
    output logic [DATA_W-1:0] A6,
    output logic [DATA_W-1:0] A7,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    logic [DATA_W-1:0] buf_q [8];
    logic [DATA_W-1:0] buf_d [8];
    logic [DATA_W-1:0] a_q [8];
    logic [DATA_W-1:0] a_d [8];
    logic [3:0]        fill_cnt_q, fill_cnt_d;
    logic              m_valid_q, m_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              accept, at_last, err, complete, slot_free, direct, pend;

    // fill_cnt==8 means a complete frame is parked waiting for the output slot
    assign s_ready = !fill_cnt_q[3];

    always_comb begin
        accept      = s_valid && s_ready;
        at_last     = fill_cnt_q == 4'd7;
        err         = accept && (s_last != at_last);
        complete    = accept && at_last && s_last;
        slot_free   = !m_valid_q || m_ready;
        direct      = complete && slot_free;
        pend        = fill_cnt_q[3] && slot_free;
        buf_d       = buf_q;
        if (accept) buf_d[fill_cnt_q[2:0]] = s_data;
        fill_cnt_d  = (err || direct || pend) ? 4'd0 :
                      complete ? 4'd8 :
                      accept ? fill_cnt_q + 4'd1 : fill_cnt_q;
        a_d         = a_q;
        if (direct) begin
            for (int i = 0; i < 7; i++) a_d[i] = buf_q[i];
            a_d[7] = s_data;
        end else if (pend) begin
            a_d = buf_q;
        end
        m_valid_d   = direct || pend || (m_valid_q && !m_ready);
        frame_err_d = err;
        frame_cnt_d = frame_cnt_q + CNT_W'(direct || pend);
        err_cnt_d   = (err && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= '0;
                a_q[i]   <= '0;
            end
            fill_cnt_q  <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            buf_q       <= buf_d;
            a_q         <= a_d;
            fill_cnt_q  <= fill_cnt_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign A0        = a_q[0];
    assign A1        = a_q[1];
    assign A2        = a_q[2];
    assign A3        = a_q[3];
    assign A4        = a_q[4];
    assign A5        = a_q[5];
    assign A6        = a_q[6];
    assign A7        = a_q[7];
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
endmodule
